// File: rtl/uart_tx_pkg.sv
// Shared state encodings, line levels and parity helper for the UART transmitter.
package uart_tx_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP1  = 3'd4;
  localparam logic [2:0] STOP2  = 3'd5;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam int unsigned MAX_DATA_W = 9;

  // Callers zero-extend narrower words; the extra zeros do not change the XOR.
  function automatic logic par_calc(input logic [MAX_DATA_W-1:0] data, input logic typ);
    return (^data) ^ typ;
  endfunction

endpackage

// File: rtl/uart_tx_baud_div.sv
// Bit-period divider: counts max(div,1) cycles per bit, restarted at each frame load.
module uart_tx_baud_div #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_restart,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div_m1;

  assign o_tick = i_en & (r_cnt == r_div_m1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_div_m1 <= '0;
    end else if (i_restart) begin
      r_cnt    <= '0;
      r_div_m1 <= (i_div == '0) ? '0 : i_div - DIV_W'(1);
    end else if (i_en) begin
      r_cnt <= o_tick ? '0 : r_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_frame_engine.sv
// UART transmitter: frame FSM, shifter, bit counter, one-word holding buffer and config latch.
module uart_tx_frame_engine
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIV_W  = 16
) (
  input  logic              clk,
  input  logic              RST,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              cfg_par_en,
  input  logic              cfg_par_typ,
  input  logic              cfg_stop2,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              tx_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic [2:0]        r_state;
  logic              r_tx;
  logic              r_done;
  logic [DATA_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_bitcnt;
  logic [DATA_W-1:0] r_buf;
  logic              r_buf_full;
  logic              r_par_en;
  logic              r_par_bit;
  logic              r_stop2;

  logic              w_tick;
  logic              w_accept;
  logic              w_frame_end;
  logic              w_load_in;
  logic              w_load;
  logic              w_to_buf;
  logic [DATA_W-1:0] w_load_word;

  always_comb begin
    w_accept    = s_valid & ~r_buf_full;
    w_frame_end = w_tick & ((r_state == STOP2) | ((r_state == STOP1) & ~r_stop2));
    w_load_in   = w_accept & ((r_state == IDLE) | w_frame_end);
    // A full buffer blocks s_ready, so at frame end only one of the two sources can load.
    w_load      = w_load_in | (w_frame_end & r_buf_full);
    w_load_word = r_buf_full ? r_buf : s_data;
    w_to_buf    = w_accept & ~w_load_in;
  end

  uart_tx_baud_div #(
    .DIV_W (DIV_W)
  ) u_baud_div (
    .i_clk     (clk),
    .i_rst     (RST),
    .i_en      (r_state != IDLE),
    .i_restart (w_load),
    .i_div     (cfg_div),
    .o_tick    (w_tick)
  );

  always_ff @(posedge clk) begin
    if (RST) begin
      r_state    <= IDLE;
      r_tx       <= STOP_BIT;
      r_done     <= 1'b0;
      r_shift    <= '0;
      r_bitcnt   <= '0;
      r_buf      <= '0;
      r_buf_full <= 1'b0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_stop2    <= 1'b0;
    end else begin
      r_done <= w_frame_end;

      if (w_to_buf) begin
        r_buf      <= s_data;
        r_buf_full <= 1'b1;
      end else if (w_load && r_buf_full) begin
        r_buf_full <= 1'b0;
      end

      if (w_load) begin
        r_state   <= START;
        r_tx      <= START_BIT;
        r_shift   <= w_load_word;
        r_bitcnt  <= '0;
        r_par_en  <= cfg_par_en;
        r_par_bit <= par_calc(MAX_DATA_W'(w_load_word), cfg_par_typ);
        r_stop2   <= cfg_stop2;
      end else if (w_tick) begin
        case (r_state)
          START: begin
            r_state  <= DATA;
            r_tx     <= r_shift[0];
            r_shift  <= r_shift >> 1;
            r_bitcnt <= '0;
          end
          DATA: begin
            if (r_bitcnt == LAST_BIT) begin
              r_state <= r_par_en ? PARITY : STOP1;
              r_tx    <= r_par_en ? r_par_bit : STOP_BIT;
            end else begin
              r_tx     <= r_shift[0];
              r_shift  <= r_shift >> 1;
              r_bitcnt <= r_bitcnt + CNT_W'(1);
            end
          end
          PARITY: begin
            r_state <= STOP1;
            r_tx    <= STOP_BIT;
          end
          STOP1: begin
            r_state <= r_stop2 ? STOP2 : IDLE;
            r_tx    <= STOP_BIT;
          end
          default: begin
            r_state <= IDLE;
            r_tx    <= STOP_BIT;
          end
        endcase
      end
    end
  end

  assign s_ready    = ~r_buf_full;
  assign busy       = (r_state != IDLE) | r_buf_full;
  assign tx_out     = r_tx;
  assign frame_done = r_done;

endmodule

// File: tb/tb_uart_tx_frame_engine.sv
// Directed bench for uart_tx_frame_engine: an 8-bit instance plus a 5-bit instance.
module tb_uart_tx_frame_engine;

  logic        clk = 1'b0;
  logic        RST;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        cfg_par_en;
  logic        cfg_par_typ;
  logic        cfg_stop2;
  logic [15:0] cfg_div;
  logic        tx_out;
  logic        busy;
  logic        frame_done;

  logic [4:0]  s_data5;
  logic        s_valid5;
  logic        s_ready5;
  logic        tx5;
  logic        busy5;
  logic        done5;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_frame_engine #(
    .DATA_W (8),
    .DIV_W  (16)
  ) dut (
    .clk         (clk),
    .RST         (RST),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .cfg_par_en  (cfg_par_en),
    .cfg_par_typ (cfg_par_typ),
    .cfg_stop2   (cfg_stop2),
    .cfg_div     (cfg_div),
    .tx_out      (tx_out),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  uart_tx_frame_engine #(
    .DATA_W (5),
    .DIV_W  (16)
  ) dut5 (
    .clk         (clk),
    .RST         (RST),
    .s_data      (s_data5),
    .s_valid     (s_valid5),
    .s_ready     (s_ready5),
    .cfg_par_en  (cfg_par_en),
    .cfg_par_typ (cfg_par_typ),
    .cfg_stop2   (cfg_stop2),
    .cfg_div     (cfg_div),
    .tx_out      (tx5),
    .busy        (busy5),
    .frame_done  (done5)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Walks one frame cycle by cycle from cycle index 'skip'; ends just after the frame-end edge.
  task automatic check_frame(input string tag, input bit which, input logic [8:0] data,
                             input int nd, input bit has_par, input bit par_bit,
                             input int nstop, input int cyc, input int skip);
    logic [12:0] seq;
    int          nbits;
    seq    = '1;
    seq[0] = 1'b0;
    for (int i = 0; i < nd; i++) seq[1+i] = data[i];
    if (has_par) seq[1+nd] = par_bit;
    nbits = 1 + nd + (has_par ? 1 : 0) + nstop;
    for (int k = skip; k < nbits * cyc; k++) begin
      chk({tag, " tx"}, which ? tx5 : tx_out, seq[k/cyc]);
      if (k > 0) chk({tag, " done_low"}, which ? done5 : frame_done, 1'b0);
      step();
    end
    chk({tag, " done_pulse"}, which ? done5 : frame_done, 1'b1);
  endtask

  initial begin
    bit seen_low, seen_done, seen_busy;
    RST = 1'b1; s_valid = 1'b0; s_data = '0; s_valid5 = 1'b0; s_data5 = '0;
    cfg_par_en = 1'b0; cfg_par_typ = 1'b0; cfg_stop2 = 1'b0; cfg_div = 16'd4;
    step(); step();
    chk("rst tx", tx_out, 1'b1);
    chk("rst busy", busy, 1'b0);
    chk("rst s_ready", s_ready, 1'b1);
    chk("rst done", frame_done, 1'b0);
    chk("rst tx5", tx5, 1'b1);
    chk("rst busy5", busy5, 1'b0);
    RST = 1'b0;

    // 0xA5, div 4, 8N1
    s_data = 8'hA5; s_valid = 1'b1; step(); s_valid = 1'b0;
    check_frame("t1", 1'b0, 9'h0A5, 8, 1'b0, 1'b0, 1, 4, 0);
    chk("t1 busy_end", busy, 1'b0);
    chk("t1 tx_idle", tx_out, 1'b1);
    chk("t1 s_ready", s_ready, 1'b1);
    step();
    chk("t1 done_1cyc", frame_done, 1'b0);

    // Parity even / odd with two stop bits, div 2
    cfg_div = 16'd2; cfg_par_en = 1'b1; cfg_par_typ = 1'b0;
    s_data = 8'h07; s_valid = 1'b1; step(); s_valid = 1'b0;
    check_frame("t2 even", 1'b0, 9'h007, 8, 1'b1, 1'b1, 1, 2, 0);
    chk("t2 busy_even", busy, 1'b0);
    cfg_par_typ = 1'b1; cfg_stop2 = 1'b1;
    s_valid = 1'b1; step(); s_valid = 1'b0;
    check_frame("t2 odd2stop", 1'b0, 9'h007, 8, 1'b1, 1'b0, 2, 2, 0);
    chk("t2 busy_odd", busy, 1'b0);
    cfg_par_en = 1'b0; cfg_par_typ = 1'b0; cfg_stop2 = 1'b0; cfg_div = 16'd4;

    // Back-to-back via the holding buffer
    s_data = 8'h11; s_valid = 1'b1; step();
    chk("t3 start", tx_out, 1'b0);
    chk("t3 ready_before", s_ready, 1'b1);
    s_data = 8'h22; step(); s_valid = 1'b0;
    chk("t3 ready_full", s_ready, 1'b0);
    chk("t3 busy_full", busy, 1'b1);
    check_frame("t3 f1", 1'b0, 9'h011, 8, 1'b0, 1'b0, 1, 4, 1);
    chk("t3 f2_start", tx_out, 1'b0);
    chk("t3 ready_after", s_ready, 1'b1);
    chk("t3 busy_mid", busy, 1'b1);
    check_frame("t3 f2", 1'b0, 9'h022, 8, 1'b0, 1'b0, 1, 4, 0);
    chk("t3 busy_end", busy, 1'b0);
    chk("t3 tx_idle", tx_out, 1'b1);

    // Config change mid-frame only affects the next frame
    s_data = 8'h3C; s_valid = 1'b1; step(); s_valid = 1'b0;
    chk("t4 start", tx_out, 1'b0);
    cfg_div = 16'd8; cfg_par_en = 1'b1; step();
    check_frame("t4 old", 1'b0, 9'h03C, 8, 1'b0, 1'b0, 1, 4, 1);
    chk("t4 busy_old", busy, 1'b0);
    s_valid = 1'b1; step(); s_valid = 1'b0;
    check_frame("t4 new", 1'b0, 9'h03C, 8, 1'b1, 1'b0, 1, 8, 0);
    chk("t4 busy_new", busy, 1'b0);
    cfg_par_en = 1'b0; cfg_div = 16'd4;

    // Reset during DATA with a buffered word
    s_data = 8'h55; s_valid = 1'b1; step();
    s_data = 8'h66; step(); s_valid = 1'b0;
    chk("t5 ready_full", s_ready, 1'b0);
    repeat (8) step();
    chk("t5 busy_pre", busy, 1'b1);
    RST = 1'b1; step();
    chk("t5 tx", tx_out, 1'b1);
    chk("t5 busy", busy, 1'b0);
    chk("t5 s_ready", s_ready, 1'b1);
    chk("t5 done", frame_done, 1'b0);
    s_data = 8'h77; s_valid = 1'b1; step();
    s_valid = 1'b0; RST = 1'b0;
    chk("t5 busy_rst_hs", busy, 1'b0);
    seen_low = 1'b0; seen_done = 1'b0; seen_busy = 1'b0;
    repeat (60) begin
      step();
      if (tx_out !== 1'b1) seen_low = 1'b1;
      if (frame_done !== 1'b0) seen_done = 1'b1;
      if (busy !== 1'b0) seen_busy = 1'b1;
    end
    chk("t5 no_tx", seen_low, 1'b0);
    chk("t5 no_done", seen_done, 1'b0);
    chk("t5 no_busy", seen_busy, 1'b0);

    // cfg_div = 0 runs one clock per bit; 5-bit instance
    cfg_div = 16'd0;
    s_data = 8'h81; s_valid = 1'b1; step(); s_valid = 1'b0;
    check_frame("t6 div0", 1'b0, 9'h081, 8, 1'b0, 1'b0, 1, 1, 0);
    chk("t6 busy", busy, 1'b0);
    s_data5 = 5'h1F; s_valid5 = 1'b1; step(); s_valid5 = 1'b0;
    check_frame("t6 w5", 1'b1, 9'h01F, 5, 1'b0, 1'b0, 1, 1, 0);
    chk("t6 busy5", busy5, 1'b0);
    chk("t6 tx5_idle", tx5, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
